// File: rtl/bcd_result_formatter.sv
// Sequential double-dabble formatter: converts a quotient/remainder pair to packed BCD,
// one bit per clock, quotient first, behind valid/ready handshakes on both sides.
module bcd_result_formatter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quo_in,
    input  logic [WIDTH-1:0]      rem_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   quo_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  busy
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConvQ,
        StConvR,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [BcdW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [WIDTH-1:0]    rem_hold_q, rem_hold_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BcdW-1:0]     quo_bcd_q, quo_bcd_d;
    logic [BcdW-1:0]     rem_bcd_q, rem_bcd_d;
    logic                init_q;

    logic [BcdW-1:0]     acc_adj;
    logic [BcdW-1:0]     acc_step;
    logic [WIDTH-1:0]    sh_step;
    logic                last_bit;

    // Per-digit +3 for digits >= 5; each nibble is independent so no carry crosses digits.
    function automatic logic [BcdW-1:0] add3(input logic [BcdW-1:0] v);
        logic [BcdW-1:0] r;
        logic [3:0]      dig;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = v[4*i +: 4];
            r[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        return r;
    endfunction

    always_comb begin
        acc_adj  = add3(acc_q);
        acc_step = {acc_adj[BcdW-2:0], sh_q[WIDTH-1]};
        sh_step  = {sh_q[WIDTH-2:0], 1'b0};
        last_bit = (cnt_q == LastCnt);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        rem_hold_d = rem_hold_q;
        cnt_d      = cnt_q;
        quo_bcd_d  = quo_bcd_q;
        rem_bcd_d  = rem_bcd_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && init_q) begin
                    sh_d       = quo_in;
                    rem_hold_d = rem_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = StConvQ;
                end
            end
            StConvQ: begin
                acc_d = acc_step;
                sh_d  = sh_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_bit) begin
                    quo_bcd_d = acc_step;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sh_d      = rem_hold_q;
                    state_d   = StConvR;
                end
            end
            StConvR: begin
                acc_d = acc_step;
                sh_d  = sh_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_bit) begin
                    rem_bcd_d = acc_step;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sh_d      = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // out_ready wins; a pending in_valid waits for the next IDLE cycle.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            sh_q       <= '0;
            rem_hold_q <= '0;
            cnt_q      <= '0;
            quo_bcd_q  <= '0;
            rem_bcd_q  <= '0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            rem_hold_q <= rem_hold_d;
            cnt_q      <= cnt_d;
            quo_bcd_q  <= quo_bcd_d;
            rem_bcd_q  <= rem_bcd_d;
            init_q     <= 1'b1;
        end
    end

    // init_q holds in_ready low until the first edge after reset release.
    assign in_ready  = (state_q == StIdle) && rst_n && init_q;
    assign busy      = (state_q == StConvQ) || (state_q == StConvR);
    assign out_valid = (state_q == StDone);
    assign quo_bcd   = quo_bcd_q;
    assign rem_bcd   = rem_bcd_q;

endmodule

// File: tb/tb_bcd_result_formatter.sv
// Directed bench for bcd_result_formatter: hand-computed BCD vectors, latency, hold,
// ignore-while-busy, mid-conversion reset and back-to-back throughput.
module tb_bcd_result_formatter;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    quo_in = '0;
    logic [WIDTH-1:0]    rem_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [4*DIGITS-1:0] quo_bcd;
    logic [4*DIGITS-1:0] rem_bcd;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    bcd_result_formatter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quo_in    (quo_in),
        .rem_in    (rem_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo_bcd   (quo_bcd),
        .rem_bcd   (rem_bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the acceptance edge.
    task automatic send(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        int k;
        in_valid = 1'b1;
        quo_in   = q;
        rem_in   = r;
        k = 0;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) check_val("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("release_ov", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int ov_seen;
        int acc_cnt;
        int res_n;
        int acc_t[2];
        logic [4*DIGITS-1:0] rq[2];
        logic [4*DIGITS-1:0] rr[2];

        // Reset state
        #2;
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_quo", 32'(quo_bcd), 32'd0);
        check_val("rst_rem", 32'(rem_bcd), 32'd0);
        #20;
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready_pre", 32'(in_ready), 32'd0);
        tick();
        check_val("rel_in_ready", 32'(in_ready), 32'd1);

        // 1234 / 7 with latency check
        send(16'd1234, 16'd7);
        check_val("t1_busy", 32'(busy), 32'd1);
        check_val("t1_in_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check_val("t1_latency", 32'(lat), 32'd32);
        check_val("t1_quo", 32'(quo_bcd), 32'h01234);
        check_val("t1_rem", 32'(rem_bcd), 32'h00007);
        release_out();

        // Full-scale quotient
        send(16'd65535, 16'd0);
        wait_valid(lat);
        check_val("t2_quo", 32'(quo_bcd), 32'h65535);
        check_val("t2_rem", 32'(rem_bcd), 32'h00000);
        for (int i = 0; i < int'(DIGITS); i++) begin
            check_val("t2_digit_le9", 32'(quo_bcd[4*i +: 4] <= 4'd9), 32'd1);
        end
        release_out();

        // Back-pressure: hold for 10 cycles
        send(16'd100, 16'd99);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check_val("t3_hold_ov", 32'(out_valid), 32'd1);
            check_val("t3_hold_quo", 32'(quo_bcd), 32'h00100);
            check_val("t3_hold_rem", 32'(rem_bcd), 32'h00099);
            check_val("t3_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t3_clear_ov", 32'(out_valid), 32'd0);
        check_val("t3_in_ready_back", 32'(in_ready), 32'd1);

        // Second pair offered while busy must be ignored until in_ready
        send(16'd77, 16'd8);
        in_valid = 1'b1;
        quo_in   = 16'd5;
        rem_in   = 16'd3;
        wait_valid(lat);
        check_val("t4_latency", 32'(lat), 32'd32);
        check_val("t4_first_quo", 32'(quo_bcd), 32'h00077);
        check_val("t4_first_rem", 32'(rem_bcd), 32'h00008);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t4_ready_after_done", 32'(in_ready), 32'd1);
        check_val("t4_not_busy_yet", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        check_val("t4_second_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check_val("t4_second_latency", 32'(lat), 32'd32);
        check_val("t4_second_quo", 32'(quo_bcd), 32'h00005);
        check_val("t4_second_rem", 32'(rem_bcd), 32'h00003);
        release_out();

        // Reset in the middle of CONV_Q
        send(16'd1234, 16'd7);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_quo", 32'(quo_bcd), 32'd0);
        check_val("t5_rst_rem", 32'(rem_bcd), 32'd0);
        check_val("t5_rst_ov", 32'(out_valid), 32'd0);
        check_val("t5_rst_busy", 32'(busy), 32'd0);
        check_val("t5_rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check_val("t5_no_out_valid", 32'(ov_seen), 32'd0);
        send(16'd42, 16'd1);
        wait_valid(lat);
        check_val("t5_quo", 32'(quo_bcd), 32'h00042);
        check_val("t5_rem", 32'(rem_bcd), 32'h00001);
        release_out();

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        quo_in    = 16'd10;
        rem_in    = 16'd2;
        acc_cnt   = 0;
        res_n     = 0;
        acc_t[0]  = 0;
        acc_t[1]  = 0;
        rq[0] = '0; rq[1] = '0; rr[0] = '0; rr[1] = '0;
        for (int c = 0; c < 150 && res_n < 2; c++) begin
            if (out_valid && res_n < 2) begin
                rq[res_n] = quo_bcd;
                rr[res_n] = rem_bcd;
                res_n++;
            end
            if (in_valid && in_ready && acc_cnt < 2) begin
                acc_t[acc_cnt] = c;
                acc_cnt++;
            end
            tick();
            if (acc_cnt == 1) begin
                quo_in = 16'd9999;
                rem_in = 16'd1;
            end
            if (acc_cnt == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("t6_accepts", 32'(acc_cnt), 32'd2);
        check_val("t6_interval", 32'(acc_t[1] - acc_t[0]), 32'd34);
        check_val("t6_results", 32'(res_n), 32'd2);
        check_val("t6_quo0", 32'(rq[0]), 32'h00010);
        check_val("t6_rem0", 32'(rr[0]), 32'h00002);
        check_val("t6_quo1", 32'(rq[1]), 32'h09999);
        check_val("t6_rem1", 32'(rr[1]), 32'h00001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
